// File: rtl/xbar_pkg.sv
// Shared definitions for the cross bar bank scheduler.
//   N_CH            default number of requesting channels
//   ADDR_HI/ADDR_LO address slice carried to the HTU (address[31:4])
//   TAG_W           default write-buffer id width
//   op_t, ch_id_t   2-bit opcode and channel index
//   slot_state_e    output slot FSM states
//   slot_req_t      registered slot contents (without the tag)
package xbar_pkg;
  localparam int N_CH    = 3;
  localparam int ADDR_HI = 31;
  localparam int ADDR_LO = 4;
  localparam int ADDR_W  = ADDR_HI - ADDR_LO + 1;
  localparam int TAG_W   = 8;

  typedef logic [1:0] op_t;
  typedef logic [1:0] ch_id_t;

  typedef enum logic {
    SLOT_EMPTY,
    SLOT_FULL
  } slot_state_e;

  typedef struct packed {
    ch_id_t              ch_id;
    op_t                 op;
    logic [ADDR_W-1:0]   addr;
  } slot_req_t;
endpackage

// File: rtl/xbar_rr_pick.sv
// Combinational round-robin picker.
//   req_i    N request bits
//   ptr_i    highest-priority channel (0..N-1)
//   onehot_o one-hot winner (all zero when nothing requests)
//   idx_o    winner index (0 when nothing requests)
// The request vector is rotated so ptr_i lands at bit 0, a fixed-priority
// find-first runs on the rotated vector, and the result is rotated back.
module xbar_rr_pick
  import xbar_pkg::*;
#(
  parameter int N = N_CH
) (
  input  logic [N-1:0] req_i,
  input  ch_id_t       ptr_i,
  output logic [N-1:0] onehot_o,
  output ch_id_t       idx_o
);

  logic [N-1:0] rot;
  logic [N-1:0] rot_oh;
  logic         found;

  // i + ptr never exceeds 2N-2, so one conditional subtract is enough.
  function automatic int mod_n(input int v);
    return (v >= N) ? v - N : v;
  endfunction

  always_comb begin
    rot      = '0;
    rot_oh   = '0;
    found    = 1'b0;
    onehot_o = '0;
    idx_o    = '0;
    // rotate: rot[i] = req[(i + ptr) mod N]
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        if (k == mod_n(i + int'(ptr_i))) rot[i] = req_i[k];
    // fixed priority, bit 0 first
    for (int i = 0; i < N; i++)
      if (rot[i] && !found) begin
        found     = 1'b1;
        rot_oh[i] = 1'b1;
      end
    // un-rotate
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++)
        if (k == mod_n(i + int'(ptr_i))) onehot_o[k] = rot_oh[i];
      if (rot_oh[i]) idx_o = ch_id_t'(mod_n(i + int'(ptr_i)));
    end
  end

endmodule

// File: rtl/cross_bar_bank_sched.sv
// Per-bank request scheduler: arbitrates the channel buffers round-robin
// into a single-entry output slot presented to the bank HTU with a
// valid/ready handshake and a rolling write-buffer id.
//   clk_i, rst_i          clock, asynchronous active-high reset
//   req_valid_i/op/addr   per-channel head entries (held until granted)
//   grant_o               one-hot dequeue pulse, combinational in capture cycle
//   htu_valid_o/ready_i   slot handshake toward the HTU
//   htu_ch_id/opcode/addr/wbuffer_id  registered slot contents
module cross_bar_bank_sched #(
  parameter int N     = xbar_pkg::N_CH,
  parameter int TAG_W = xbar_pkg::TAG_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [N-1:0]      req_valid_i,
  input  logic [2*N-1:0]    req_op_i,
  input  logic [28*N-1:0]   req_addr_i,
  output logic [N-1:0]      grant_o,
  output logic              htu_valid_o,
  input  logic              htu_ready_i,
  output logic [1:0]        htu_ch_id_o,
  output logic [1:0]        htu_opcode_o,
  output logic [27:0]       htu_addr_o,
  output logic [TAG_W-1:0]  htu_wbuffer_id_o
);
  import xbar_pkg::*;

  slot_state_e      state_q, state_d;
  ch_id_t           ptr_q, ptr_d;
  logic [TAG_W-1:0] tag_cnt_q, tag_cnt_d;
  slot_req_t        slot_q, slot_d;
  logic [TAG_W-1:0] slot_tag_q, slot_tag_d;

  logic [N-1:0]     pick_oh;
  ch_id_t           pick_idx;
  logic             load_en;
  logic             capture;

  xbar_rr_pick #(.N(N)) u_pick (
    .req_i    (req_valid_i),
    .ptr_i    (ptr_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx)
  );

  assign htu_valid_o      = (state_q == SLOT_FULL);
  // A full slot being drained this cycle can be refilled on the same edge.
  assign load_en          = !htu_valid_o || htu_ready_i;
  assign capture          = load_en && (|req_valid_i);

  assign htu_ch_id_o      = slot_q.ch_id;
  assign htu_opcode_o     = slot_q.op;
  assign htu_addr_o       = slot_q.addr;
  assign htu_wbuffer_id_o = slot_tag_q;

  // Slot FSM next state
  always_comb begin
    state_d = state_q;
    if (state_q == SLOT_EMPTY) begin
      if (capture) state_d = SLOT_FULL;
    end else begin
      if (htu_ready_i && !capture) state_d = SLOT_EMPTY;
    end
  end

  // Pick, grant and slot load
  always_comb begin
    grant_o    = '0;
    ptr_d      = ptr_q;
    tag_cnt_d  = tag_cnt_q;
    slot_d     = slot_q;
    slot_tag_d = slot_tag_q;
    if (capture) begin
      grant_o      = pick_oh;
      ptr_d        = (pick_idx == ch_id_t'(N - 1)) ? '0 : pick_idx + 2'd1;
      tag_cnt_d    = tag_cnt_q + TAG_W'(1);
      slot_tag_d   = tag_cnt_q;
      slot_d.ch_id = pick_idx;
      for (int i = 0; i < N; i++)
        if (pick_oh[i]) begin
          slot_d.op   = req_op_i[2*i +: 2];
          slot_d.addr = req_addr_i[ADDR_W*i +: ADDR_W];
        end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= SLOT_EMPTY;
      ptr_q      <= '0;
      tag_cnt_q  <= '0;
      slot_q     <= '0;
      slot_tag_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tag_cnt_q  <= tag_cnt_d;
      slot_q     <= slot_d;
      slot_tag_q <= slot_tag_d;
    end
  end

endmodule

// File: tb/tb_cross_bar_bank_sched.sv
module tb_cross_bar_bank_sched;
  localparam int N = 3;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [N-1:0]  req_valid;
  logic [2*N-1:0]  req_op;
  logic [28*N-1:0] req_addr;
  logic [N-1:0]  grant_o;
  logic          htu_valid_o;
  logic          htu_ready;
  logic [1:0]    htu_ch_id_o;
  logic [1:0]    htu_opcode_o;
  logic [27:0]   htu_addr_o;
  logic [7:0]    htu_wbuffer_id_o;

  cross_bar_bank_sched #(.N(N), .TAG_W(8)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .req_valid_i      (req_valid),
    .req_op_i         (req_op),
    .req_addr_i       (req_addr),
    .grant_o          (grant_o),
    .htu_valid_o      (htu_valid_o),
    .htu_ready_i      (htu_ready),
    .htu_ch_id_o      (htu_ch_id_o),
    .htu_opcode_o     (htu_opcode_o),
    .htu_addr_o       (htu_addr_o),
    .htu_wbuffer_id_o (htu_wbuffer_id_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0]  ch;
    logic [1:0]  op;
    logic [27:0] addr;
    logic [7:0]  tag;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic       m_vld;
  int         m_ptr;
  logic [7:0] m_tag;
  int         m_w;
  logic       m_cap;
  exp_t       m_e;

  function automatic int rr_ref(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_ch(input int i, input logic [1:0] op, input logic [27:0] a);
    req_op[2*i +: 2]    = op;
    req_addr[28*i +: 28] = a;
  endtask

  // Monitor: checks every grant against the model, and every accepted slot
  // against the scoreboard entry pushed when it was granted.
  always @(negedge clk_i) begin
    #4;
    if (rst_i) begin
      m_vld = 1'b0;
      m_ptr = 0;
      m_tag = '0;
      sb.delete();
    end else begin
      chk("mon_valid", 64'(htu_valid_o), 64'(m_vld));
      m_w   = rr_ref(req_valid, m_ptr);
      m_cap = (!m_vld || htu_ready) && (m_w >= 0);
      chk("mon_grant", 64'(grant_o), m_cap ? 64'(1) << m_w : 64'(0));
      if (m_vld && htu_ready) begin
        if (sb.size() == 0) chk("sb_empty", 64'(1), 64'(0));
        else begin
          m_e = sb.pop_front();
          chk("sb_ch",   64'(htu_ch_id_o),      64'(m_e.ch));
          chk("sb_op",   64'(htu_opcode_o),     64'(m_e.op));
          chk("sb_addr", 64'(htu_addr_o),       64'(m_e.addr));
          chk("sb_tag",  64'(htu_wbuffer_id_o), 64'(m_e.tag));
        end
        m_vld = 1'b0;
      end
      if (m_cap) begin
        m_e.ch   = 2'(m_w);
        m_e.op   = req_op[2*m_w +: 2];
        m_e.addr = req_addr[28*m_w +: 28];
        m_e.tag  = m_tag;
        sb.push_back(m_e);
        m_tag = m_tag + 8'd1;
        m_ptr = (m_w + 1) % N;
        m_vld = 1'b1;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b1; req_valid = '0; htu_ready = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  localparam logic [27:0] A0  = 28'h0A0A0A0;
  localparam logic [27:0] A1  = 28'h0000123;
  localparam logic [27:0] A2  = 28'h0C0C0C0;
  localparam logic [27:0] A2B = 28'h00B0B0B;

  initial begin
    rst_i = 1'b1; req_valid = '0; req_op = '0; req_addr = '0; htu_ready = 1'b0;
    do_reset();
    #2;
    chk("rst_valid", 64'(htu_valid_o), 64'(0));
    chk("rst_ch",    64'(htu_ch_id_o), 64'(0));
    chk("rst_op",    64'(htu_opcode_o), 64'(0));
    chk("rst_addr",  64'(htu_addr_o), 64'(0));
    chk("rst_tag",   64'(htu_wbuffer_id_o), 64'(0));
    chk("rst_grant", 64'(grant_o), 64'(0));

    // single request from ch1
    @(negedge clk_i);
    set_ch(1, 2'b01, A1); req_valid = 3'b010;
    #2 chk("t1_grant", 64'(grant_o), 64'(3'b010));
    @(negedge clk_i);
    req_valid = '0;
    #2;
    chk("t1_valid", 64'(htu_valid_o), 64'(1));
    chk("t1_ch",    64'(htu_ch_id_o), 64'(1));
    chk("t1_addr",  64'(htu_addr_o), 64'(A1));
    chk("t1_op",    64'(htu_opcode_o), 64'(2'b01));
    chk("t1_tag",   64'(htu_wbuffer_id_o), 64'(0));

    // all channels requesting, ready held high
    do_reset();
    set_ch(0, 2'b00, A0); set_ch(1, 2'b01, A1); set_ch(2, 2'b11, A2);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk_i);
      req_valid = 3'b111; htu_ready = 1'b1;
      #2;
      chk("rr_grant", 64'(grant_o), 64'(1) << (c % 3));
      if (c > 0) chk("rr_tag", 64'(htu_wbuffer_id_o), 64'(c - 1));
    end

    // backpressure: slot holds ch2/tag5 while ch2 waits
    @(negedge clk_i);
    req_valid = '0; htu_ready = 1'b0;
    #2 chk("rr_tag_last", 64'(htu_wbuffer_id_o), 64'(5));
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      set_ch(2, 2'b10, A2B); req_valid = 3'b100; htu_ready = 1'b0;
      #2;
      chk("bp_grant", 64'(grant_o), 64'(0));
      chk("bp_valid", 64'(htu_valid_o), 64'(1));
      chk("bp_ch",    64'(htu_ch_id_o), 64'(2));
      chk("bp_addr",  64'(htu_addr_o), 64'(A2));
      chk("bp_tag",   64'(htu_wbuffer_id_o), 64'(5));
    end
    @(negedge clk_i);
    htu_ready = 1'b1;
    #2 chk("bp_rel_grant", 64'(grant_o), 64'(3'b100));
    @(negedge clk_i);
    req_valid = '0; htu_ready = 1'b0;
    #2;
    chk("bp_new_ch",   64'(htu_ch_id_o), 64'(2));
    chk("bp_new_addr", 64'(htu_addr_o), 64'(A2B));
    chk("bp_new_op",   64'(htu_opcode_o), 64'(2'b10));
    chk("bp_new_tag",  64'(htu_wbuffer_id_o), 64'(6));

    // drain without refill, ptr stays at 0
    @(negedge clk_i);
    htu_ready = 1'b1;
    #2 chk("dr_grant", 64'(grant_o), 64'(0));
    @(negedge clk_i);
    #2 chk("dr_valid", 64'(htu_valid_o), 64'(0));
    @(negedge clk_i);
    req_valid = 3'b011;
    #2 chk("dr_ptr_grant", 64'(grant_o), 64'(3'b001));
    @(negedge clk_i);
    req_valid = '0;
    #2 chk("dr_ch", 64'(htu_ch_id_o), 64'(0));

    // tag wrap
    do_reset();
    htu_ready = 1'b1;
    set_ch(0, 2'b11, A0);
    for (int i = 0; i < 255; i++) begin
      @(negedge clk_i);
      req_valid = 3'b001;
    end
    @(negedge clk_i);
    #2 chk("wrap_254", 64'(htu_wbuffer_id_o), 64'(254));
    @(negedge clk_i);
    #2 chk("wrap_255", 64'(htu_wbuffer_id_o), 64'(255));
    @(negedge clk_i);
    req_valid = '0; htu_ready = 1'b0;
    #2 chk("wrap_0", 64'(htu_wbuffer_id_o), 64'(0));
    chk("wrap_valid", 64'(htu_valid_o), 64'(1));

    // asynchronous reset with the slot full
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", 64'(htu_valid_o), 64'(0));
    chk("arst_addr",  64'(htu_addr_o), 64'(0));
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
    set_ch(1, 2'b01, A1); set_ch(2, 2'b11, A2);
    req_valid = 3'b110; htu_ready = 1'b1;
    #2 chk("arst_grant", 64'(grant_o), 64'(3'b010));
    @(negedge clk_i);
    req_valid = '0; htu_ready = 1'b0;
    #2;
    chk("arst_ch",   64'(htu_ch_id_o), 64'(1));
    chk("arst_tag",  64'(htu_wbuffer_id_o), 64'(0));
    chk("arst_addr2", 64'(htu_addr_o), 64'(A1));

    @(negedge clk_i);
    #5;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
